// File: rtl/dram_rd_pkg.sv
// Shared constants and types for the DRAM read arbiter.
// Fixed burst shape: 128-byte bursts of 16 beats x 8 bytes, INCR.
package dram_rd_pkg;

   localparam int          BURST_BYTES   = 128;
   localparam int          BEAT_BYTES    = 8;
   localparam int          BURST_BEATS   = BURST_BYTES / BEAT_BYTES;

   localparam logic [3:0]  AXI_ARLEN      = 4'(BURST_BEATS - 1);
   localparam logic [1:0]  AXI_ARSIZE     = 2'b11;
   localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
   localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

   typedef enum logic {
      AR_IDLE,
      AR_VALID
   } ar_state_t;

endpackage : dram_rd_pkg

// File: rtl/dram_rd_order_fifo.sv
// Issue-order FIFO of requester ids for outstanding read bursts.
// Depth must be a power of 2 so the pointers wrap naturally.
// The occupancy count doubles as the outstanding-burst count.
module dram_rd_order_fifo #(
   parameter  int WIDTH = 1,
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic             fclk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   localparam int          PW       = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full   = (r_count == FULL_CNT);
   assign o_empty  = (r_count == '0);
   assign o_count  = r_count;
   assign o_head   = r_mem[r_rd_ptr];
   assign w_push   = i_push && !o_full;
   assign w_pop    = i_pop && !o_empty;

   // Storage write; contents are only ever read behind a valid count.
   // NOTE: the array has no reset -- pointers and count define validity, so clearing it buys nothing.
   always_ff @(posedge fclk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // Pointer and occupancy tracking; push+pop together leaves count unchanged.
   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge fclk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : dram_rd_order_fifo

// File: rtl/dram_read_arbiter.sv
// Round-robin arbiter sharing one AXI3 HP read port between NUM_REQ
// burst requesters. AR grants are recorded in an order FIFO so each
// R beat is routed back to the requester that issued the burst.
// Optional build macro: DRAM_RD_ARB_STATS_EN adds per-requester
// completed-burst counters and sticky RRESP error flags.
module dram_read_arbiter
   import dram_rd_pkg::*;
#(
   parameter int NUM_REQ         = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  fclk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*32-1:0] req_addr,
   output logic [NUM_REQ-1:0]    rd_valid,
   input  logic [NUM_REQ-1:0]    rd_ready,
   output logic [63:0]           rd_data,
   output logic                  rd_last,
   output logic                  M2S_AXI_ARVALID,
   input  logic                  M2S_AXI_ARREADY,
   output logic [31:0]           M2S_AXI_ARADDR,
   output logic [3:0]            M2S_AXI_ARLEN,
   output logic [1:0]            M2S_AXI_ARSIZE,
   output logic [1:0]            M2S_AXI_ARBURST,
   input  logic                  M2S_AXI_RVALID,
   output logic                  M2S_AXI_RREADY,
   input  logic                  M2S_AXI_RLAST,
   input  logic [63:0]           M2S_AXI_RDATA,
   input  logic [1:0]            M2S_AXI_RRESP
`ifdef DRAM_RD_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0] stat_bursts,
   output logic [NUM_REQ-1:0]    stat_rresp_err
`endif
);

   localparam int              IDW     = $clog2(NUM_REQ);
   localparam int              CW      = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [IDW-1:0]  LAST_ID = IDW'(NUM_REQ - 1);
   localparam logic [CW-1:0]   OUT_MAX = CW'(MAX_OUTSTANDING);

   ar_state_t          r_state;
   ar_state_t          w_state_nxt;
   logic [IDW-1:0]     r_rr_ptr;
   logic [NUM_REQ-1:0] r_req_ready;
   logic [31:0]        r_araddr;
   logic [IDW-1:0]     w_grant_id;
   logic [IDW-1:0]     w_head;
   logic [CW-1:0]      w_outstanding;
   logic               w_empty;
   logic               w_unused_full;
   logic               w_grant;
   logic               w_beat_hs;
   logic               w_pop;

   // First requester at or after ptr (wrapping). Scanning from the far end
   // down lets the nearest valid requester win without an early exit.
   function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [IDW-1:0]     ptr);
      logic [IDW-1:0] pick;
      int             idx;
      pick = ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (valid[idx]) begin
            pick = IDW'(idx);
         end
      end
      return pick;
   endfunction

   assign w_grant_id = rr_pick(req_valid, r_rr_ptr);
   assign w_grant    = (r_state == AR_IDLE) && (|req_valid) && (w_outstanding < OUT_MAX);
   assign w_beat_hs  = M2S_AXI_RVALID && M2S_AXI_RREADY;
   assign w_pop      = w_beat_hs && M2S_AXI_RLAST;

   dram_rd_order_fifo #(
      .WIDTH (IDW),
      .DEPTH (MAX_OUTSTANDING)
   ) u_order_fifo (
      .fclk        (fclk),
      .rst         (rst),
      .i_push      (w_grant),
      .i_push_data (w_grant_id),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_full      (w_unused_full),
      .o_empty     (w_empty),
      .o_count     (w_outstanding)
   );

   // AR FSM state register.
   always_ff @(posedge fclk) begin
      if (rst) begin
         r_state <= AR_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // AR FSM next state: grant from IDLE, return once the address is accepted.
   // NOTE: default assignment first so no path leaves w_state_nxt unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         AR_IDLE:  if (w_grant)         w_state_nxt = AR_VALID;
         AR_VALID: if (M2S_AXI_ARREADY) w_state_nxt = AR_IDLE;
         default:                       w_state_nxt = AR_IDLE;
      endcase
   end

   // Grant-time registers: address capture, one-cycle accept pulse, pointer advance.
   always_ff @(posedge fclk) begin
      if (rst) begin
         r_araddr    <= '0;
         r_req_ready <= '0;
         r_rr_ptr    <= '0;
      end else begin
         r_req_ready <= '0;
         if (w_grant) begin
            r_araddr    <= req_addr[32*w_grant_id +: 32];
            r_req_ready <= NUM_REQ'(1) << w_grant_id;
            r_rr_ptr    <= (w_grant_id == LAST_ID) ? '0 : w_grant_id + IDW'(1);
         end
      end
   end

   // Outputs: ARVALID is the AR_VALID state; R path steered by the FIFO head.
   always_comb begin
      M2S_AXI_ARVALID = (r_state == AR_VALID);
      M2S_AXI_RREADY  = !w_empty && rd_ready[w_head];
      rd_valid        = '0;
      if (M2S_AXI_RVALID && !w_empty) begin
         rd_valid[w_head] = 1'b1;
      end
   end

   assign M2S_AXI_ARADDR  = r_araddr;
   assign M2S_AXI_ARLEN   = AXI_ARLEN;
   assign M2S_AXI_ARSIZE  = AXI_ARSIZE;
   assign M2S_AXI_ARBURST = AXI_BURST_INCR;
   assign req_ready       = r_req_ready;
   assign rd_data         = M2S_AXI_RDATA;
   assign rd_last         = M2S_AXI_RLAST;

`ifdef DRAM_RD_ARB_STATS_EN
   logic [NUM_REQ*16-1:0] r_stat_bursts;
   logic [NUM_REQ-1:0]    r_stat_rresp_err;

   // Per-requester burst completions (wrapping) and sticky error-response flags.
   always_ff @(posedge fclk) begin
      if (rst) begin
         r_stat_bursts    <= '0;
         r_stat_rresp_err <= '0;
      end else begin
         if (w_beat_hs && (M2S_AXI_RRESP != AXI_RESP_OKAY)) begin
            r_stat_rresp_err[w_head] <= 1'b1;
         end
         if (w_pop) begin
            r_stat_bursts[16*w_head +: 16] <= r_stat_bursts[16*w_head +: 16] + 16'd1;
         end
      end
   end

   assign stat_bursts    = r_stat_bursts;
   assign stat_rresp_err = r_stat_rresp_err;
`else
   // Response code is only consumed by the statistics block.
   logic w_unused_rresp;
   assign w_unused_rresp = (M2S_AXI_RRESP != AXI_RESP_OKAY);
`endif

endmodule : dram_read_arbiter

// File: tb/tb_dram_read_arbiter.sv
// Directed self-checking bench for dram_read_arbiter (NUM_REQ=2, MAX_OUTSTANDING=4).
// Statistics checks are compiled in when DRAM_RD_ARB_STATS_EN is defined.
`timescale 1ns/1ps
module tb_dram_read_arbiter;

   logic        fclk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_addr;
   logic [1:0]  rd_valid;
   logic [1:0]  rd_ready;
   logic [63:0] rd_data;
   logic        rd_last;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [1:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid;
   logic        rready;
   logic        rlast;
   logic [63:0] rdata;
   logic [1:0]  rresp;
`ifdef DRAM_RD_ARB_STATS_EN
   logic [31:0] stat_bursts;
   logic [1:0]  stat_rresp_err;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int hs_cnt   = 0;
   int hs_base;
   int stray;

   always #5 fclk = ~fclk;

   // Independent count of AR handshakes seen on the port.
   always @(posedge fclk) if (arvalid && arready) hs_cnt <= hs_cnt + 1;

   dram_read_arbiter #(
      .NUM_REQ         (2),
      .MAX_OUTSTANDING (4)
   ) dut (
      .fclk            (fclk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_addr        (req_addr),
      .rd_valid        (rd_valid),
      .rd_ready        (rd_ready),
      .rd_data         (rd_data),
      .rd_last         (rd_last),
      .M2S_AXI_ARVALID (arvalid),
      .M2S_AXI_ARREADY (arready),
      .M2S_AXI_ARADDR  (araddr),
      .M2S_AXI_ARLEN   (arlen),
      .M2S_AXI_ARSIZE  (arsize),
      .M2S_AXI_ARBURST (arburst),
      .M2S_AXI_RVALID  (rvalid),
      .M2S_AXI_RREADY  (rready),
      .M2S_AXI_RLAST   (rlast),
      .M2S_AXI_RDATA   (rdata),
      .M2S_AXI_RRESP   (rresp)
`ifdef DRAM_RD_ARB_STATS_EN
      ,
      .stat_bursts     (stat_bursts),
      .stat_rresp_err  (stat_rresp_err)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge fclk);
      #2;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      rvalid    = 1'b0;
      rlast     = 1'b0;
      rresp     = 2'b00;
      repeat (2) cyc();
      rst = 1'b0;
   endtask

   // Wait (bounded) for ARVALID, then check the granted requester and address.
   task automatic expect_grant(input int id, input logic [31:0] addr);
      logic seen;
      logic [1:0] oh;
      oh   = 2'b01 << id;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cyc();
         seen = arvalid;
      end
      check("ar_seen", 64'(seen), 64'd1);
      check("ar_grant", 64'(req_ready), 64'(oh));
      check("ar_addr", 64'(araddr), 64'(addr));
   endtask

   // Drive one 16-beat burst with the consumer always ready; check routing per beat.
   task automatic send_burst(input int id, input logic [63:0] seed, input int err_beat);
      logic [1:0] oh;
      oh = 2'b01 << id;
      for (int b = 0; b < 16; b++) begin
         rvalid = 1'b1;
         rdata  = seed + 64'(b);
         rlast  = (b == 15);
         rresp  = (b == err_beat) ? 2'b10 : 2'b00;
         #1;
         check($sformatf("r_route_id%0d_b%0d", id, b), 64'({rd_valid, rready, rd_last}),
               64'({oh, 1'b1, (b == 15)}));
         check("r_data", rd_data, seed + 64'(b));
         cyc();
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 2'b11;
      req_addr  = '0;
      rd_ready  = 2'b11;
      arready   = 1'b1;
      rvalid    = 1'b1;
      rlast     = 1'b0;
      rdata     = '0;
      rresp     = 2'b00;

      // Reset values, with requests and a stray beat present.
      repeat (2) cyc();
      check("rst_arvalid", 64'(arvalid), 64'd0);
      check("rst_araddr", 64'(araddr), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rready", 64'(rready), 64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      do_reset();

      // Single requester: one-cycle accept latency, constant burst shape, 16 beats to id0.
      req_valid = 2'b01;
      req_addr  = {32'h0, 32'h1000_0000};
      arready   = 1'b1;
      #1;
      check("t1_arvalid_pre", 64'(arvalid), 64'd0);
      expect_grant(0, 32'h1000_0000);
      check("t1_arlen", 64'(arlen), 64'hF);
      check("t1_arsize", 64'(arsize), 64'h3);
      check("t1_arburst", 64'(arburst), 64'h1);
      req_valid = 2'b00;
      cyc();
      check("t1_arvalid_drop", 64'(arvalid), 64'd0);
      check("t1_req_ready_pulse", 64'(req_ready), 64'd0);
      send_burst(0, 64'h1111_0000_0000_0000, -1);
      check("t1_rready_empty", 64'(rready), 64'd0);
      do_reset();

      // Both requesters continuously valid: grants alternate, stop at 4 outstanding.
      req_valid = 2'b11;
      req_addr  = {32'h0000_B000, 32'h0000_A000};
      arready   = 1'b1;
      hs_base   = hs_cnt;
      expect_grant(0, 32'h0000_A000);
      req_addr[31:0] = 32'h0000_A080;
      expect_grant(1, 32'h0000_B000);
      req_addr[63:32] = 32'h0000_B080;
      expect_grant(0, 32'h0000_A080);
      req_addr[31:0] = 32'h0000_A100;
      expect_grant(1, 32'h0000_B080);
      req_valid = 2'b01;
      stray = 0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (arvalid || (req_ready != 2'b00)) stray++;
      end
      check("t4_full_blocks", 64'(stray), 64'd0);
      check("t4_hs_4", 64'(hs_cnt - hs_base), 64'd4);
      send_burst(0, 64'hA000_0000_0000_0000, -1);
      check("t4_no_ar_at_rlast", 64'(arvalid), 64'd0);
      cyc();
      check("t4_5th_arvalid", 64'(arvalid), 64'd1);
      check("t4_5th_addr", 64'(araddr), 64'h0000_A100);
      check("t4_5th_ready", 64'(req_ready), 64'h1);
      req_valid = 2'b00;
      send_burst(1, 64'hB000_0000_0000_0000, -1);
      send_burst(0, 64'hA080_0000_0000_0000, -1);
      send_burst(1, 64'hB080_0000_0000_0000, -1);
      send_burst(0, 64'hA100_0000_0000_0000, -1);
      check("t4_hs_5", 64'(hs_cnt - hs_base), 64'd5);
      rvalid = 1'b1;
      #1;
      check("t2_stray_rready", 64'(rready), 64'd0);
      check("t2_stray_rd_valid", 64'(rd_valid), 64'd0);
      rvalid = 1'b0;
      do_reset();

      // ARREADY low: address held, no second grant, single accept pulse.
      arready   = 1'b0;
      req_valid = 2'b11;
      req_addr  = {32'h3000_0000, 32'h2000_0000};
      expect_grant(0, 32'h2000_0000);
      req_addr[31:0] = 32'h2000_0080;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("t3_hold_valid", 64'(arvalid), 64'd1);
         check("t3_hold_addr", 64'(araddr), 64'h2000_0000);
         check("t3_no_regrant", 64'(req_ready), 64'd0);
      end
      arready = 1'b1;
      cyc();
      check("t3_accepted", 64'(arvalid), 64'd0);
      expect_grant(1, 32'h3000_0000);
      req_valid = 2'b00;

      // Reset with bursts outstanding and a beat on the bus.
      rst    = 1'b1;
      rvalid = 1'b1;
      cyc();
      check("rst_mid_rready", 64'(rready), 64'd0);
      check("rst_mid_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_mid_arvalid", 64'(arvalid), 64'd0);
      do_reset();

      // Head id1 back-pressured by its consumer; id0 data follows after release.
      arready   = 1'b1;
      req_valid = 2'b10;
      req_addr  = {32'h5000_0000, 32'h4000_0000};
      expect_grant(1, 32'h5000_0000);
      req_valid = 2'b01;
      expect_grant(0, 32'h4000_0000);
      req_valid = 2'b00;
      rd_ready  = 2'b01;
      rvalid    = 1'b1;
      rdata     = 64'h5555_0000_0000_0000;
      #1;
      check("t5_rready_held", 64'(rready), 64'd0);
      check("t5_rd_valid_id1", 64'(rd_valid), 64'h2);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("t5_still_held", 64'({rd_valid, rready}), 64'({2'b10, 1'b0}));
      end
      rd_ready = 2'b11;
      send_burst(1, 64'h5555_0000_0000_0000, -1);
      send_burst(0, 64'h4444_0000_0000_0000, -1);
      check("t5_drained", 64'(rready), 64'd0);

`ifdef DRAM_RD_ARB_STATS_EN
      // Error response on beat 3 of a requester-1 burst.
      do_reset();
      check("t6_stats_clear", 64'({stat_rresp_err, stat_bursts}), 64'd0);
      req_valid = 2'b10;
      req_addr  = {32'h6000_0000, 32'h0};
      expect_grant(1, 32'h6000_0000);
      req_valid = 2'b00;
      send_burst(1, 64'h6666_0000_0000_0000, 3);
      repeat (3) cyc();
      check("t6_rresp_err", 64'(stat_rresp_err), 64'h2);
      check("t6_bursts1", 64'(stat_bursts[31:16]), 64'd1);
      check("t6_bursts0", 64'(stat_bursts[15:0]), 64'd0);
      do_reset();
      check("t6_err_cleared", 64'(stat_rresp_err), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_dram_read_arbiter
